// File: rtl/joker_spi_arb.sv
// Two-master Wishbone arbiter for the shared spi_top slave, with grant held across locked transactions.
// Optional cycle watchdog compiled in with `define JOKER_SPI_ARB_TMO_EN.
module joker_spi_arb #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [4:0]  m0_adr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_dat_w,
    input  logic        m0_lock,
    output logic [31:0] m0_dat_r,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [4:0]  m1_adr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_dat_w,
    input  logic        m1_lock,
    output logic [31:0] m1_dat_r,
    output logic        m1_ack,
    output logic        m1_err,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [4:0]  s_adr,
    output logic [3:0]  s_sel,
    output logic [31:0] s_dat_w,
    input  logic [31:0] s_dat_r,
    input  logic        s_ack,
    input  logic        s_err,

    output logic [1:0]  grant,
    output logic        busy,
    output logic [7:0]  tmo_cnt
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, FLUSH} state_t;

    state_t state, state_nxt;
    logic   pri, pri_nxt;
    logic   owner, owner_nxt;
    logic   tmo_hit;
    logic [1:0] err_route;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pri   <= 1'b0;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            pri   <= pri_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pri_nxt   = pri;
        owner_nxt = owner;
        unique case (state)
            IDLE: begin
                if (m0_cyc && (!m1_cyc || !pri)) begin
                    state_nxt = OWN0;
                    pri_nxt   = 1'b1;
                    owner_nxt = 1'b0;
                end else if (m1_cyc) begin
                    state_nxt = OWN1;
                    pri_nxt   = 1'b0;
                    owner_nxt = 1'b1;
                end
            end
            OWN0: begin
                if (tmo_hit) begin
                    state_nxt = FLUSH;
                end else if (!m0_cyc && !m0_lock) begin
                    if (m1_cyc) begin
                        state_nxt = OWN1;
                        pri_nxt   = 1'b0;
                        owner_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            OWN1: begin
                if (tmo_hit) begin
                    state_nxt = FLUSH;
                end else if (!m1_cyc && !m1_lock) begin
                    if (m0_cyc) begin
                        state_nxt = OWN0;
                        pri_nxt   = 1'b1;
                        owner_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (owner ? !m1_cyc : !m0_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        unique case (state)
            OWN0:    grant = 2'b01;
            OWN1:    grant = 2'b10;
            default: grant = '0;
        endcase
        busy = |grant;

        // Slave errors keep reaching the flushed owner even though its grant is gone.
        err_route = grant | ((state == FLUSH) ? {owner, ~owner} : 2'b00);

        s_cyc   = (grant[0] & m0_cyc) | (grant[1] & m1_cyc);
        s_stb   = (grant[0] & m0_stb) | (grant[1] & m1_stb);
        s_we    = (grant[0] & m0_we)  | (grant[1] & m1_we);
        s_adr   = ({5{grant[0]}}  & m0_adr)   | ({5{grant[1]}}  & m1_adr);
        s_sel   = ({4{grant[0]}}  & m0_sel)   | ({4{grant[1]}}  & m1_sel);
        s_dat_w = ({32{grant[0]}} & m0_dat_w) | ({32{grant[1]}} & m1_dat_w);

        m0_dat_r = grant[0] ? s_dat_r : '0;
        m1_dat_r = grant[1] ? s_dat_r : '0;
        m0_ack   = grant[0] & s_ack;
        m1_ack   = grant[1] & s_ack;
        m0_err   = (err_route[0] & s_err) | (tmo_hit & ~owner);
        m1_err   = (err_route[1] & s_err) | (tmo_hit &  owner);
    end

`ifdef JOKER_SPI_ARB_TMO_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TMO_CYCLES);

    logic [7:0] wdt;
    logic [7:0] tmo_q;

    assign tmo_hit = (state == OWN0 || state == OWN1) && (wdt == TMO_LIMIT);
    assign tmo_cnt = tmo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt   <= '0;
            tmo_q <= '0;
        end else begin
            if (state_nxt != state || s_ack) begin
                wdt <= '0;
            end else if (s_cyc && s_stb) begin
                wdt <= wdt + 8'd1;
            end
            if (tmo_hit && tmo_q != 8'hFF) begin
                tmo_q <= tmo_q + 8'd1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_cnt = '0;
`endif

endmodule
